// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment width
// and the active-high hex glyph table (bit0 = a .. bit6 = g).
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_enc.sv
// Combinational hex-to-segment decoder with a blanking override.
// Output is active-high; polarity is applied by the caller.
module seg7_enc
  import seg7_pkg::*;
(
  input  logic [3:0]       hex,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = blank ? '0 : SEG_TABLE[hex];
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// Time-multiplexed hex display driver with frame-synchronous double-buffered
// loads, per-digit enable/blink and live leading-zero suppression.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [4*N_DIG-1:0] iDIG,
  input  logic [N_DIG-1:0]   iON_OFF,
  input  logic [N_DIG-1:0]   iBLINK,
  input  logic               iLZS,
  input  logic               iLOAD,
  output logic [SEG_W-1:0]   oSEG,
  output logic [N_DIG-1:0]   oAN,
  output logic               oACK,
  output logic               oFRAME
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BL_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(SCAN_DIV - 1);
  localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_DIV - 1);

  // XOR masks double as the reset (all-off) value for the chosen polarity.
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACTIVE_LOW}};
  localparam logic [N_DIG-1:0] AN_OFF  = {N_DIG{ACTIVE_LOW}};

  logic [PS_W-1:0]    ps_cnt;
  logic [IDX_W-1:0]   idx;
  logic [BL_W-1:0]    bl_cnt;
  logic               phase;
  logic               pending;
  logic               tick;
  logic               frame;

  logic [4*N_DIG-1:0] sh_dig;
  logic [N_DIG-1:0]   sh_on;
  logic [N_DIG-1:0]   sh_blk;
  logic [4*N_DIG-1:0] act_dig;
  logic [N_DIG-1:0]   act_on;
  logic [N_DIG-1:0]   act_blk;

  logic [N_DIG-1:0]   zero_run;
  logic               run;
  logic [N_DIG-1:0]   blank_vec;
  logic [N_DIG-1:0]   an_sel;
  logic [3:0]         cur_hex;
  logic [SEG_W-1:0]   seg_raw;
  logic [SEG_W-1:0]   seg_p1;
  logic [N_DIG-1:0]   an_p1;

  assign tick  = (ps_cnt == PS_LAST);
  assign frame = tick && (idx == IDX_LAST);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ps_cnt <= '0;
      idx    <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Active registers only ever change on a frame boundary, so a frame is
  // always drawn from one consistent snapshot.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sh_dig  <= '0;
      sh_on   <= '0;
      sh_blk  <= '0;
      act_dig <= '0;
      act_on  <= '0;
      act_blk <= '0;
      pending <= 1'b0;
    end else begin
      if (iLOAD) begin
        sh_dig <= iDIG;
        sh_on  <= iON_OFF;
        sh_blk <= iBLINK;
      end
      if (frame) begin
        pending <= 1'b0;
        if (iLOAD) begin
          act_dig <= iDIG;
          act_on  <= iON_OFF;
          act_blk <= iBLINK;
        end else if (pending) begin
          act_dig <= sh_dig;
          act_on  <= sh_on;
          act_blk <= sh_blk;
        end
      end else if (iLOAD) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bl_cnt <= '0;
      phase  <= 1'b0;
    end else if (frame) begin
      if (bl_cnt == BL_LAST) begin
        bl_cnt <= '0;
        phase  <= ~phase;
      end else begin
        bl_cnt <= bl_cnt + 1'b1;
      end
    end
  end

  // zero_run[k]: digits k..N_DIG-1 are all zero in the active snapshot.
  always_comb begin
    zero_run = '0;
    run      = 1'b1;
    for (int k = N_DIG - 1; k >= 0; k--) begin
      run         = run && (act_dig[4*k +: 4] == 4'h0);
      zero_run[k] = run;
    end
  end

  always_comb begin
    blank_vec = '0;
    for (int k = 0; k < N_DIG; k++) begin
      blank_vec[k] = !act_on[k] || (act_blk[k] && phase) ||
                     (iLZS && (k > 0) && zero_run[k]);
    end
  end

  always_comb begin
    an_sel      = '0;
    an_sel[idx] = 1'b1;
  end

  assign cur_hex = act_dig[4*int'(idx) +: 4];

  seg7_enc u_enc (
    .hex   (cur_hex),
    .blank (blank_vec[idx]),
    .seg   (seg_raw)
  );

  // Stage p1: registered, polarity-adjusted pad drive.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      seg_p1 <= SEG_OFF;
      an_p1  <= AN_OFF;
    end else begin
      seg_p1 <= seg_raw ^ SEG_OFF;
      an_p1  <= an_sel ^ AN_OFF;
    end
  end

  assign oSEG   = seg_p1;
  assign oAN    = an_p1;
  assign oFRAME = frame && !iRST;
  assign oACK   = frame && (pending || iLOAD) && !iRST;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv at N_DIG=4, SCAN_DIV=2, BLINK_DIV=2,
// active-high outputs: table of load vectors plus hand-written sequences.
module tb_seg7_scan_drv;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [15:0] iDIG = '0;
  logic [3:0]  iON_OFF = '0;
  logic [3:0]  iBLINK = '0;
  logic        iLZS = 1'b0;
  logic        iLOAD = 1'b0;
  logic [6:0]  oSEG;
  logic [3:0]  oAN;
  logic        oACK;
  logic        oFRAME;

  int tests = 0;
  int failed = 0;
  int fcnt = 0;

  seg7_scan_drv #(
    .N_DIG(4), .SCAN_DIV(2), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iDIG(iDIG), .iON_OFF(iON_OFF),
    .iBLINK(iBLINK), .iLZS(iLZS), .iLOAD(iLOAD),
    .oSEG(oSEG), .oAN(oAN), .oACK(oACK), .oFRAME(oFRAME)
  );

  always #5 iCLK = ~iCLK;

  // Frame boundaries seen since reset; drives the blink-phase model.
  always @(negedge iCLK) begin
    if (iRST) fcnt <= 0;
    else if (oFRAME) fcnt <= fcnt + 1;
  end

  typedef struct {
    logic [15:0]     dig;
    logic [3:0]      on;
    logic            lzs;
    logic [3:0][6:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    int n;
    for (n = 0; n < 40; n++) begin
      @(negedge iCLK);
      if (oFRAME) break;
    end
    chk("frame_timeout", 32'(n < 40), 1);
  endtask

  // Returns aligned so the next negedge shows digit 0 of the new frame.
  task automatic load(input logic [15:0] dig, input logic [3:0] on,
                      input logic [3:0] blk, output bit got);
    got = 1'b0;
    @(negedge iCLK);
    iDIG = dig; iON_OFF = on; iBLINK = blk; iLOAD = 1'b1;
    #1 got = oACK;
    @(negedge iCLK);
    iLOAD = 1'b0;
    if (!got) begin
      for (int n = 0; n < 40; n++) begin
        #1;
        if (oACK) begin
          got = 1'b1;
          break;
        end
        @(negedge iCLK);
      end
      @(negedge iCLK);
    end
  endtask

  task automatic collect_frame(input string tag, input logic [3:0][6:0] exp,
                               output int acks);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      if (oACK) acks++;
      chk({tag, "_an"}, oAN, 32'(4'b0001 << (i / 2)));
      chk({tag, "_seg"}, oSEG, exp[i / 2]);
    end
  endtask

  initial begin
    bit got;
    int acks;

    vecs[0] = '{16'h12AF, 4'hF, 1'b0, {7'h06, 7'h5B, 7'h77, 7'h71}};
    vecs[1] = '{16'h0070, 4'hF, 1'b1, {7'h00, 7'h00, 7'h07, 7'h3F}};
    vecs[2] = '{16'h0070, 4'hF, 1'b0, {7'h3F, 7'h3F, 7'h07, 7'h3F}};
    vecs[3] = '{16'h0000, 4'hF, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
    vecs[4] = '{16'h3456, 4'h5, 1'b0, {7'h00, 7'h66, 7'h00, 7'h7D}};
    vecs[5] = '{16'h89BC, 4'hF, 1'b0, {7'h7F, 7'h6F, 7'h7C, 7'h39}};
    vecs[6] = '{16'hDE07, 4'hF, 1'b1, {7'h5E, 7'h79, 7'h3F, 7'h07}};

    // Reset state.
    repeat (3) @(negedge iCLK);
    chk("rst_seg", oSEG, 0);
    chk("rst_an", oAN, 0);
    chk("rst_ack", oACK, 0);
    chk("rst_frame", oFRAME, 0);
    iRST = 1'b0;

    // Free-running scan with nothing loaded.
    for (int k = 0; k < 16; k++) begin
      @(negedge iCLK);
      chk("scan_an", oAN, 32'(4'b0001 << ((k / 2) % 4)));
      chk("scan_seg", oSEG, 0);
      chk("scan_frame", oFRAME, 32'((k % 8) == 6));
      chk("scan_ack", oACK, 0);
    end

    foreach (vecs[v]) begin
      iLZS = vecs[v].lzs;
      load(vecs[v].dig, vecs[v].on, 4'h0, got);
      chk($sformatf("vec%0d_ack", v), 32'(got), 1);
      collect_frame($sformatf("vec%0d", v), vecs[v].exp, acks);
    end
    iLZS = 1'b0;

    // Two loads in one frame: last wins, one acknowledge.
    wait_frame();
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      iLOAD = (i < 2);
      iDIG = (i == 0) ? 16'h1111 : 16'h2222;
      iON_OFF = 4'hF;
      #1 if (oACK) acks++;
    end
    chk("dbl_ack_count", 32'(acks), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge iCLK);
      chk("dbl_seg", oSEG, 7'h5B);
      chk("dbl_an_onehot", 32'($onehot(oAN)), 1);
    end

    // Load coincident with a frame boundary goes straight to active.
    wait_frame();
    iDIG = 16'h5678; iON_OFF = 4'hF; iLOAD = 1'b1;
    #1 chk("coin_ack", oACK, 1);
    @(negedge iCLK);
    iLOAD = 1'b0;
    collect_frame("coin", {7'h6D, 7'h7D, 7'h07, 7'h7F}, acks);
    chk("coin_no_pending", 32'(acks), 0);

    // Blink on digit 0: dark while the phase (2 frames per half) is 1.
    load(16'h2222, 4'hF, 4'b0001, got);
    chk("blink_ack", 32'(got), 1);
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge iCLK);
        if (oAN == 4'b0001 && ((fcnt / 2) % 2) == 1) chk("blink_dark", oSEG, 0);
        else chk("blink_lit", oSEG, 7'h5B);
      end
    end

    // Reset with a load pending: no acknowledge, display restarts blank.
    wait_frame();
    @(negedge iCLK);
    iDIG = 16'h1234; iON_OFF = 4'hF; iBLINK = 4'h0; iLOAD = 1'b1;
    @(negedge iCLK);
    iLOAD = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("rst2_seg", oSEG, 0);
    chk("rst2_an", oAN, 0);
    chk("rst2_ack", oACK, 0);
    chk("rst2_frame", oFRAME, 0);
    repeat (2) @(negedge iCLK);
    iRST = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge iCLK);
      chk("post_rst_ack", oACK, 0);
      chk("post_rst_seg", oSEG, 0);
      chk("post_rst_an", oAN, 32'(4'b0001 << ((i / 2) % 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seg7_scan_drv.md
SEG7_SCAN_DRV -- requirements
Module: seg7_scan_drv

Interface
REQ-001 SHALL have parameter N_DIG, default 8, number of hex digits, range 1..16.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, iCLK cycles per digit slot, minimum 1.
REQ-003 SHALL have parameter BLINK_DIV, default 64, full scan frames per blink half-period, minimum 1.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1, 1 = oSEG/oAN asserted low.
REQ-005 iCLK  in  1  sole clock, rising edge.
REQ-006 iRST  in  1  reset, asynchronous, active-high.
REQ-007 iDIG  in  4*N_DIG  hex digits, digit k = iDIG[4k+3:4k].
REQ-008 iON_OFF  in  N_DIG  per-digit enable, 0 = blank.
REQ-009 iBLINK  in  N_DIG  per-digit blink enable.
REQ-010 iLZS  in  1  leading-zero suppression enable, sampled live.
REQ-011 iLOAD  in  1  single-cycle strobe capturing iDIG/iON_OFF/iBLINK.
REQ-012 oSEG  out  7  segments of selected digit, bit0=a .. bit6=g.
REQ-013 oAN  out  N_DIG  one-hot digit select.
REQ-014 oACK  out  1  one-cycle pulse when loaded data becomes displayed.
REQ-015 oFRAME  out  1  one-cycle pulse on each frame boundary.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = prescaler at SCAN_DIV-1.
REQ-017 Digit index SHALL increment on tick, wrapping N_DIG-1 -> 0; frame boundary = tick with index N_DIG-1.
REQ-018 iLOAD SHALL write shadow registers and set pending; repeated loads before a boundary SHALL overwrite shadow (last wins).
REQ-019 On a frame boundary with pending set, active registers SHALL take shadow, pending SHALL clear, oACK SHALL pulse that cycle.
REQ-020 iLOAD coincident with a frame boundary SHALL transfer iLOAD data directly to active registers and pulse oACK; pending SHALL remain clear.
REQ-021 Active data SHALL never change except at a frame boundary (no tearing).
REQ-022 Blink counter SHALL count frames 0..BLINK_DIV-1; blink phase SHALL toggle on its wrap; phase 1 = blinking digits dark.
REQ-023 Digit k SHALL be blank when active ON_OFF[k]=0, or active BLINK[k]=1 and phase=1, or iLZS=1, k>0 and digits k..N_DIG-1 are all zero.
REQ-024 Digit 0 SHALL never be zero-suppressed.
REQ-025 Non-blank encoding (active-high, hex 0..F): 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-026 Blank SHALL drive all segments off; ACTIVE_LOW=1 SHALL invert oSEG and oAN.
REQ-027 oSEG/oAN SHALL be registered, reflecting digit index one cycle after index changes.
REQ-028 oFRAME SHALL pulse in the boundary cycle, irrespective of pending.

Reset
REQ-029 On iRST: prescaler, index, blink counter, phase, pending, shadow and active registers SHALL be 0.
REQ-030 During reset oSEG and oAN SHALL be all-off (all-ones when ACTIVE_LOW=1); oACK and oFRAME SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard pending load with no oACK.
REQ-032 First registered output after reset release SHALL select digit 0 (blank, ON_OFF=0).

Structure
REQ-033 Package seg7_pkg SHALL hold the 16-entry segment table constant and segment width constant.
REQ-034 Sub-module seg7_enc SHALL implement combinational hex-to-segment decode with blank input; one instance.

Verification (N_DIG=4, SCAN_DIV=2, BLINK_DIV=2, ACTIVE_LOW=0)
REQ-035 Reset release, no load -> oAN cycles 0001,0010,0100,1000 every 2 clocks, oSEG=00, oFRAME every 8 clocks.
REQ-036 iLOAD iDIG=16'h12AF, ON_OFF=F mid-frame -> oACK at next boundary; then oSEG 71,77,5B,06 for digits 0..3.
REQ-037 Two loads (1111 then 2222) within one frame -> single oACK, all digits show 5B.
REQ-038 iDIG=16'h0070, ON_OFF=F, iLZS=1 -> digits 3,2 blank, digit1=07, digit0=3F; iLZS=0 -> digits 3,2 show 3F.
REQ-039 BLINK=4'b0001 -> digit 0 dark for 2 frames, lit 2 frames, repeating; others steady.
REQ-040 iRST pulse with load pending -> no oACK, outputs all-off, display resumes blank at digit 0.
